data_ram_wbuf: RTL

DATA_RAM_WBUF -- requirements
Module: data_ram_wbuf

---
 rtl/data_ram_wbuf_pkg.sv | 29 ++
 rtl/data_ram_array.sv | 28 ++
 rtl/data_ram_wbuf.sv | 122 ++++++++++++
 3 files changed

// File: rtl/data_ram_wbuf_pkg.sv
// Shared constants and the posted-write entry record for the buffered data RAM.
package data_ram_wbuf_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefAw    = 10;
  localparam int unsigned NumLanes = 4;
  localparam int unsigned ByteW    = 8;
  localparam int unsigned WordW    = NumLanes * ByteW;
  // Widest possible word index (addr[31:2]); narrower indices are zero-extended.
  localparam int unsigned IdxW     = 30;

  typedef struct packed {
    logic [IdxW-1:0]     index;
    logic [NumLanes-1:0] mask;
    logic [WordW-1:0]    data;
  } wbuf_entry_t;

  function automatic logic [WordW-1:0] merge_lanes(input logic [WordW-1:0]    old_word,
                                                   input logic [WordW-1:0]    new_word,
                                                   input logic [NumLanes-1:0] mask);
    logic [WordW-1:0] res;
    res = old_word;
    for (int l = 0; l < NumLanes; l++) begin
      if (mask[l]) res[l*ByteW +: ByteW] = new_word[l*ByteW +: ByteW];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Backing word array: one combinational read port, one synchronous byte-masked write port.
module data_ram_array
  import data_ram_wbuf_pkg::*;
#(
  parameter int unsigned AW = DefAw
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [NumLanes-1:0] wmask,
  input  logic [WordW-1:0]    wdata,
  input  logic [AW-1:0]       raddr,
  output logic [WordW-1:0]    rdata
);

  logic [WordW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (wmask[l]) mem[waddr][l*ByteW +: ByteW] <= wdata[l*ByteW +: ByteW];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_ram_wbuf.sv
// Data RAM with a posted-write buffer: stores are queued and drained to the array in idle
// cycles, loads see buffered bytes through per-lane forwarding.
module data_ram_wbuf
  import data_ram_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DefAw
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [3:0]          sel,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic                stall_o,
  output logic                buf_empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wbuf_entry_t       entries_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PtrW-1:0]   head_q, tail_q, youngest;
  logic [CntW-1:0]   count_q, count_d;
  logic              buf_empty_q;

  logic              is_load, is_store, is_idle;
  logic              full, empty, drain, coalesce, accept;
  logic [IdxW-1:0]   idx_ext;
  logic [WordW-1:0]  arr_rdata, fwd_word;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign idx_ext     = IdxW'(addr[AW+1:2]);

  assign is_load  = ce & ~we;
  assign is_store = ce & we;
  assign is_idle  = ~ce;

  assign youngest = tail_q - PtrW'(1);
  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign drain    = is_idle & ~empty;

  // Merging into the head while it is being written out would lose the merged bytes.
  assign coalesce = is_store & ~empty & valid_q[youngest] &
                    (entries_q[youngest].index == idx_ext) &
                    ~(drain & (youngest == head_q));
  assign accept   = is_store & (~full | coalesce);
  assign stall_o  = is_store & full & ~coalesce;

  always_comb begin
    count_d = count_q;
    if (accept && !coalesce) count_d = count_q + CntW'(1);
    else if (drain)          count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      buf_empty_q <= 1'b1;
    end else begin
      if (accept && !coalesce) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      count_q     <= count_d;
      buf_empty_q <= (count_d == '0);
    end
  end

  // Entry payload needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (coalesce) begin
        entries_q[youngest].mask <= entries_q[youngest].mask | sel;
        entries_q[youngest].data <= merge_lanes(entries_q[youngest].data, data_i, sel);
      end else begin
        entries_q[tail_q] <= '{index: idx_ext, mask: sel, data: data_i};
      end
    end
  end

  data_ram_array #(
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .we   (drain),
    .waddr(entries_q[head_q].index[AW-1:0]),
    .wmask(entries_q[head_q].mask),
    .wdata(entries_q[head_q].data),
    .raddr(addr[AW+1:2]),
    .rdata(arr_rdata)
  );

  // Walk oldest to youngest so the youngest matching entry wins each lane.
  always_comb begin
    logic [PtrW-1:0] pos;
    pos      = '0;
    fwd_word = arr_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && valid_q[pos] && (entries_q[pos].index == idx_ext)) begin
        fwd_word = merge_lanes(fwd_word, entries_q[pos].data, entries_q[pos].mask);
      end
    end
  end

  assign data_o      = is_load ? fwd_word : '0;
  assign buf_empty_o = buf_empty_q;

endmodule
